// File: rtl/vga_pkg.sv
// Shared definitions for the VGA scan-out block: register map, FSM
// state encoding and the reset value of the replication registers.
package vga_pkg;

  localparam logic [1:0] REG_HSCALE  = 2'd0;
  localparam logic [1:0] REG_VSCALE  = 2'd1;
  localparam logic [1:0] REG_FLIP    = 2'd2;
  localparam logic [1:0] REG_IRQ_CLR = 2'd3;

  localparam int unsigned RST_SCALE = 3;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/vga_scale_counter.sv
// Divide-by-(scale+1) sub-counter feeding a wrapping index counter.
// Used once for columns (advance per pixel) and once for rows (per line).
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : zero both sub-counter and index (priority over advance)
//   advance    : step the sub-counter; index steps when sub reaches scale
//   scale      : replication factor minus one
//   index      : current index, wraps at 2**IDX_W
module vga_scale_counter #(
  parameter int unsigned SCALE_W = 6,
  parameter int unsigned IDX_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               advance,
  input  logic [SCALE_W-1:0] scale,
  output logic [IDX_W-1:0]   index
);

  logic [SCALE_W-1:0] sub;

  // Index wraps naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sub   <= '0;
      index <= '0;
    end else if (clear) begin
      sub   <= '0;
      index <= '0;
    end else if (advance) begin
      if (sub == scale) begin
        sub   <= '0;
        index <= index + IDX_W'(1);
      end else begin
        sub <= sub + SCALE_W'(1);
      end
    end
  end

endmodule

// File: rtl/vga_scanout_sequencer.sv
// Turns beam events into a 1-bpp VRAM bit index with pixel replication,
// and owns double-buffer bank selection (flips commit at frame start).
//   clk, rst_n                    : clock, synchronous active-low reset
//   frame_start/line_start        : beam pulses from vga_timing
//   pixel_valid                   : beam in visible area
//   cfg_we/cfg_addr/cfg_wdata     : CPU register writes
//   vram_index                    : {display_bank,row,col}, combinational
//   pixel_en                      : index valid to display, combinational
//   display_bank/write_bank       : scanned bank / CPU-filled bank
//   flip_pending, frame_count, irq: flip status and interrupt
module vga_scanout_sequencer
  import vga_pkg::*;
#(
  parameter int unsigned COLS    = 16,
  parameter int unsigned ROWS    = 16,
  parameter int unsigned SCALE_W = 6
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   frame_start,
  input  logic                                   line_start,
  input  logic                                   pixel_valid,
  input  logic                                   cfg_we,
  input  logic [1:0]                             cfg_addr,
  input  logic [SCALE_W-1:0]                     cfg_wdata,
  output logic [$clog2(ROWS)+$clog2(COLS):0]     vram_index,
  output logic                                   pixel_en,
  output logic                                   display_bank,
  output logic                                   write_bank,
  output logic                                   flip_pending,
  output logic [7:0]                             frame_count,
  output logic                                   irq
);

  localparam int unsigned COL_W = $clog2(COLS);
  localparam int unsigned ROW_W = $clog2(ROWS);

  state_t state_q, state_d;

  logic [SCALE_W-1:0] hscale_sh, vscale_sh, hscale_act, vscale_act;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic               h_clr, h_adv, v_clr, v_adv;

  logic wr_hscale, wr_vscale, wr_flip, wr_irq_clr, commit;

  assign wr_hscale  = cfg_we && (cfg_addr == REG_HSCALE);
  assign wr_vscale  = cfg_we && (cfg_addr == REG_VSCALE);
  assign wr_flip    = cfg_we && (cfg_addr == REG_FLIP);
  assign wr_irq_clr = cfg_we && (cfg_addr == REG_IRQ_CLR);
  assign commit     = frame_start && flip_pending;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= SYNC;
    else        state_q <= state_d;
  end

  // Next state and counter control; frame_start outranks line_start.
  always_comb begin
    state_d  = state_q;
    pixel_en = 1'b0;
    h_clr    = frame_start;
    v_clr    = frame_start;
    h_adv    = 1'b0;
    v_adv    = 1'b0;
    case (state_q)
      SYNC: begin
        if (frame_start) state_d = RUN;
      end
      RUN: begin
        pixel_en = pixel_valid;
        h_clr    = frame_start || line_start;
        h_adv    = pixel_valid && !line_start && !frame_start;
        v_adv    = line_start && !frame_start;
      end
      default: state_d = SYNC;
    endcase
  end

  // Shadow/active scale registers; active only reloads at frame start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hscale_sh  <= SCALE_W'(RST_SCALE);
      vscale_sh  <= SCALE_W'(RST_SCALE);
      hscale_act <= SCALE_W'(RST_SCALE);
      vscale_act <= SCALE_W'(RST_SCALE);
    end else begin
      if (wr_hscale) hscale_sh <= cfg_wdata;
      if (wr_vscale) vscale_sh <= cfg_wdata;
      if (frame_start) begin
        hscale_act <= hscale_sh;
        vscale_act <= vscale_sh;
      end
    end
  end

  // Bank flip bookkeeping: a new request on a commit cycle stays pending,
  // and an irq set beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      display_bank <= 1'b0;
      flip_pending <= 1'b0;
      irq          <= 1'b0;
      frame_count  <= 8'd0;
    end else begin
      flip_pending <= wr_flip || (flip_pending && !frame_start);
      irq          <= commit || (irq && !wr_irq_clr);
      if (commit) begin
        display_bank <= ~display_bank;
        frame_count  <= frame_count + 8'd1;
      end
    end
  end

  assign write_bank = ~display_bank;
  assign vram_index = {display_bank, row, col};

  vga_scale_counter #(.SCALE_W(SCALE_W), .IDX_W(COL_W)) u_hcnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (h_clr),
    .advance (h_adv),
    .scale   (hscale_act),
    .index   (col)
  );

  vga_scale_counter #(.SCALE_W(SCALE_W), .IDX_W(ROW_W)) u_vcnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (v_clr),
    .advance (v_adv),
    .scale   (vscale_act),
    .index   (row)
  );

endmodule

// File: tb/tb_vga_scanout_sequencer.sv
// Directed bench for vga_scanout_sequencer: column/row replication,
// deferred scale changes, bank flips with coincident events, mid-frame reset.
module tb_vga_scanout_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_start, line_start, pixel_valid;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [5:0] cfg_wdata;
  logic [8:0] vram_index;
  logic       pixel_en, display_bank, write_bank, flip_pending, irq;
  logic [7:0] frame_count;

  int n_cmp = 0;
  int n_err = 0;

  vga_scanout_sequencer #(.COLS(16), .ROWS(16), .SCALE_W(6)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_start  (frame_start),
    .line_start   (line_start),
    .pixel_valid  (pixel_valid),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .vram_index   (vram_index),
    .pixel_en     (pixel_en),
    .display_bank (display_bank),
    .write_bank   (write_bank),
    .flip_pending (flip_pending),
    .frame_count  (frame_count),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] a, input logic [5:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    step();
    cfg_we    = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pixel_en"}, int'(pixel_en), 0);
    check({tag, "_index"}, int'(vram_index), 0);
    check({tag, "_dbank"}, int'(display_bank), 0);
    check({tag, "_wbank"}, int'(write_bank), 1);
    check({tag, "_pending"}, int'(flip_pending), 0);
    check({tag, "_fcount"}, int'(frame_count), 0);
    check({tag, "_irq"}, int'(irq), 0);
  endtask

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; line_start = 1'b0; pixel_valid = 1'b0;
    cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 6'd0;
    repeat (3) step();
    check_reset_outputs("rst");

    // SYNC ignores pixel_valid until a frame starts
    rst_n = 1'b1;
    pixel_valid = 1'b1;
    step();
    check("sync_pixel_en", int'(pixel_en), 0);

    // Frame start, then 64 pixels with hscale=3: one column per 4 clocks
    frame_start = 1'b1; line_start = 1'b1;
    step();
    frame_start = 1'b0; line_start = 1'b0;
    check("run_pixel_en", int'(pixel_en), 1);
    for (int k = 0; k < 64; k++) begin
      check("h4_index", int'(vram_index), k / 4);
      step();
    end
    check("h4_wrap", int'(vram_index), 0);

    // vscale=1 (takes effect at frame start); two lines per row
    pixel_valid = 1'b0;
    cfg(2'd1, 6'd1);
    frame_start = 1'b1; line_start = 1'b1; pixel_valid = 1'b1;
    step();
    frame_start = 1'b0; line_start = 1'b0;
    check("v_row0", int'(vram_index), 0);
    for (int j = 1; j <= 8; j++) begin
      line_start = 1'b1;
      step();
      line_start = 1'b0;
      check("v_line_index", int'(vram_index), (j / 2) * 16);
      repeat (5) step();
      check("v_col_after5", int'(vram_index[3:0]), 1);
    end

    // hscale=0 written mid-frame: old spacing holds until frame start
    pixel_valid = 1'b0;
    cfg(2'd0, 6'd0);
    line_start = 1'b1; pixel_valid = 1'b1;
    step();
    line_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("hdefer_col", int'(vram_index[3:0]), k / 4);
      step();
    end
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      check("h1_col", int'(vram_index[3:0]), k % 16);
      step();
    end

    // Double flip request commits once at frame start
    pixel_valid = 1'b0;
    cfg(2'd2, 6'd0);
    check("flip_req_pending", int'(flip_pending), 1);
    check("flip_req_bank", int'(display_bank), 0);
    cfg(2'd2, 6'd0);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("flip1_dbank", int'(display_bank), 1);
    check("flip1_wbank", int'(write_bank), 0);
    check("flip1_fcount", int'(frame_count), 1);
    check("flip1_irq", int'(irq), 1);
    check("flip1_pending", int'(flip_pending), 0);
    check("flip1_idx_bank", int'(vram_index[8]), 1);

    cfg(2'd3, 6'd0);
    check("irq_clear", int'(irq), 0);

    // Flip write coincident with a committing frame start
    cfg(2'd2, 6'd0);
    frame_start = 1'b1;
    cfg(2'd2, 6'd0);
    frame_start = 1'b0;
    check("coflip_dbank", int'(display_bank), 0);
    check("coflip_pending", int'(flip_pending), 1);
    check("coflip_fcount", int'(frame_count), 2);
    check("coflip_irq", int'(irq), 1);

    // Irq clear coincident with a commit: set wins
    frame_start = 1'b1;
    cfg(2'd3, 6'd0);
    frame_start = 1'b0;
    check("coclr_dbank", int'(display_bank), 1);
    check("coclr_pending", int'(flip_pending), 0);
    check("coclr_fcount", int'(frame_count), 3);
    check("coclr_irq", int'(irq), 1);
    cfg(2'd3, 6'd0);
    check("irq_clear2", int'(irq), 0);

    // Reset mid-frame
    pixel_valid = 1'b1;
    repeat (3) step();
    check("pre_rst_pixel_en", int'(pixel_en), 1);
    rst_n = 1'b0;
    step();
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    repeat (3) step();
    check("post_rst_pixel_en", int'(pixel_en), 0);
    check("post_rst_index", int'(vram_index), 0);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("resume_pixel_en", int'(pixel_en), 1);
    for (int k = 0; k < 8; k++) begin
      check("resume_col", int'(vram_index), k / 4);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
